// File: rtl/wb_write_arbiter.sv
// rtl/wb_write_arbiter.sv - register-file writeback arbiter: ALU priority, in-order MDU queue with squash
// Optional feature macro: WB_BYPASS_EN (MDU result skips the empty queue and is written next cycle)
module wb_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_rd,
  input  logic [DATA_W-1:0]        alu_data,
  input  logic                     mdu_valid,
  input  logic [4:0]               mdu_rd,
  input  logic [DATA_W-1:0]        mdu_data,
  output logic                     mdu_ready,
  output logic                     RegWrite,
  output logic [4:0]               Write_register,
  output logic [DATA_W-1:0]        Write_data,
  output logic [31:0]              pending,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // A slot stays occupied after a squash (so ordering and pointers are untouched);
  // only its live bit drops, and the drain simply discards it when it reaches the head.
  logic [DEPTH-1:0]  q_live;
  logic [4:0]        q_rd   [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;

  logic alu_take;
  logic mdu_write;
  logic pop;
  logic bypass;
  logic push;

  // Per-cycle decisions: ALU wins the write port, otherwise the queue head drains
  always_comb begin
    alu_take  = alu_valid && (alu_rd != 5'd0);
    mdu_write = mdu_valid && mdu_ready && (mdu_rd != 5'd0);
    pop       = !alu_take && (count != '0);
`ifdef WB_BYPASS_EN
    bypass    = mdu_write && !alu_take && (count == '0);
`else
    bypass    = 1'b0;
`endif
    push      = mdu_write && !bypass;
  end

  assign mdu_ready = (count < DEPTH_C);
  assign q_count   = count;

  // Pending scoreboard: one bit per register still owed by a live queue entry
  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_live[i]) pending[q_rd[i]] = 1'b1;
    end
  end

  // Queue control: squash, pop and push; the push comes last so a same-cycle
  // ALU write to the same register never kills the younger MDU entry
  always_ff @(posedge clk) begin
    if (rst) begin
      q_live <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (alu_take) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (q_live[i] && (q_rd[i] == alu_rd)) q_live[i] <= 1'b0;
        end
      end
      if (pop) begin
        q_live[rd_ptr] <= 1'b0;
        rd_ptr         <= rd_ptr + 1'b1;
      end
      if (push) begin
        q_live[wr_ptr] <= 1'b1;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Queue payload storage; no reset needed because live bits gate every use
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      q_rd[wr_ptr]   <= mdu_rd;
      q_data[wr_ptr] <= mdu_data;
    end
  end

  // Registered register-file write port
  always_ff @(posedge clk) begin
    if (rst) begin
      RegWrite       <= 1'b0;
      Write_register <= 5'd0;
      Write_data     <= '0;
    end else if (alu_take) begin
      RegWrite       <= 1'b1;
      Write_register <= alu_rd;
      Write_data     <= alu_data;
    end else if (pop && q_live[rd_ptr]) begin
      RegWrite       <= 1'b1;
      Write_register <= q_rd[rd_ptr];
      Write_data     <= q_data[rd_ptr];
    end else if (bypass) begin
      RegWrite       <= 1'b1;
      Write_register <= mdu_rd;
      Write_data     <= mdu_data;
    end else begin
      RegWrite       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb/tb_wb_write_arbiter.sv - scoreboard bench for wb_write_arbiter with a queue-based reference model
module tb_wb_write_arbiter;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   alu_valid;
  logic [4:0]             alu_rd;
  logic [DATA_W-1:0]      alu_data;
  logic                   mdu_valid;
  logic [4:0]             mdu_rd;
  logic [DATA_W-1:0]      mdu_data;
  logic                   mdu_ready;
  logic                   RegWrite;
  logic [4:0]             Write_register;
  logic [DATA_W-1:0]      Write_data;
  logic [31:0]            pending;
  logic [$clog2(DEPTH):0] q_count;

  wb_write_arbiter #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
    .mdu_ready(mdu_ready),
    .RegWrite(RegWrite), .Write_register(Write_register), .Write_data(Write_data),
    .pending(pending), .q_count(q_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          live;
  } ent_t;

  typedef struct {
    bit          we;
    bit          chk_regs;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] pend;
    int          cnt;
    bit          rdy;
  } exp_t;

  ent_t mq[$];
  exp_t eq[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus and push the model's expected post-edge state
  task automatic cyc(input bit r, input bit av, input logic [4:0] ard, input logic [31:0] ad,
                     input bit mv, input logic [4:0] mrd, input logic [31:0] md);
    exp_t e;
    ent_t n;
    bit   take;
    bit   acc;
    bit   byp;
    rst = r; alu_valid = av; alu_rd = ard; alu_data = ad;
    mdu_valid = mv; mdu_rd = mrd; mdu_data = md;
    e.we = 1'b0; e.chk_regs = 1'b0; e.rd = 5'd0; e.data = 32'd0;
    if (r) begin
      mq.delete();
      e.chk_regs = 1'b1;
    end else begin
      take = av && (ard != 5'd0);
      acc  = mv && (mq.size() < DEPTH) && (mrd != 5'd0);
      byp  = 1'b0;
      if (take) begin
        e.we = 1'b1; e.rd = ard; e.data = ad;
        foreach (mq[i]) if (mq[i].rd == ard) mq[i].live = 1'b0;
      end else if (mq.size() > 0) begin
        n = mq.pop_front();
        if (n.live) begin
          e.we = 1'b1; e.rd = n.rd; e.data = n.data;
        end
      end else if (BYP && acc) begin
        e.we = 1'b1; e.rd = mrd; e.data = md;
        byp = 1'b1;
      end
      if (acc && !byp) begin
        n.rd = mrd; n.data = md; n.live = 1'b1;
        mq.push_back(n);
      end
    end
    e.pend = 32'd0;
    foreach (mq[i]) if (mq[i].live) e.pend[mq[i].rd] = 1'b1;
    e.cnt = mq.size();
    e.rdy = (mq.size() < DEPTH);
    eq.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
  endtask

  // Monitor: one expectation per clock edge, checked just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (eq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_underflow actual=0 expected=1 at %0t", $time);
      end else begin
        e = eq.pop_front();
        chk("RegWrite", {31'd0, RegWrite}, {31'd0, e.we});
        if (e.we || e.chk_regs) begin
          chk("Write_register", {27'd0, Write_register}, {27'd0, e.rd});
          chk("Write_data", Write_data, e.data);
        end
        chk("pending", pending, e.pend);
        chk("q_count", 32'(q_count), 32'(e.cnt));
        chk("mdu_ready", {31'd0, mdu_ready}, {31'd0, e.rdy});
      end
    end
  end

  initial begin
    bit          r;
    bit          av;
    bit          mv;
    logic [4:0]  ard;
    logic [4:0]  mrd;
    // reset
    cyc(1, 1, 5'd4, 32'h55, 1, 5'd6, 32'h66);
    cyc(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    // ALU single-cycle write
    cyc(0, 1, 5'd5, 32'h1234, 0, 5'd0, 32'd0);
    idle(1);
    // MDU write through the queue (or bypass)
    cyc(0, 0, 5'd0, 32'd0, 1, 5'd7, 32'hAA);
    idle(3);
    // fill the queue while ALU owns the port, then drain
    for (int k = 0; k < 5; k++)
      cyc(0, 1, 5'(20 + k), 32'(k), 1, 5'(k + 1), 32'(32'h100 + k));
    idle(6);
    // squash of a queued rd=3 by a later ALU write to r3
    cyc(0, 1, 5'd9, 32'h99, 1, 5'd3, 32'h11);
    cyc(0, 1, 5'd3, 32'h22, 0, 5'd0, 32'd0);
    idle(3);
    // rd=0 requests are swallowed
    cyc(0, 1, 5'd0, 32'hDEAD, 1, 5'd0, 32'hBEEF);
    cyc(0, 1, 5'd0, 32'h1, 1, 5'd0, 32'h2);
    idle(2);
    // reset with three entries queued
    for (int k = 0; k < 3; k++)
      cyc(0, 1, 5'(24 + k), 32'(k), 1, 5'(10 + k), 32'(32'h200 + k));
    cyc(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    idle(4);
    // randomized traffic with a narrow rd range to provoke squashes and duplicates
    for (int i = 0; i < 2000; i++) begin
      r   = ($urandom_range(0, 149) == 0);
      av  = ($urandom_range(0, 99) < 45);
      mv  = ($urandom_range(0, 99) < 55);
      ard = 5'($urandom_range(0, 7));
      mrd = 5'($urandom_range(0, 7));
      cyc(r, av, ard, $urandom, mv, mrd, $urandom);
    end
    idle(6);
    chk("scoreboard_drained", 32'(eq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
